io_channel_bank: RTL and testbench
==================================

Name: io_channel_bank

Overview:
- Sits directly downstream of the Core's IO write port and feeds the Core's IO read port.
- Holds 32 × 15-bit I/O channel registers.
  - Output channels are written by the Core; each Core write is also queued as an event for external peripherals (DSKY, telemetry).
  - Input channels are written by peripherals through a valid/ready port.
- Read path is combinational so the Core samples it in its decode stage.

Parameters:
- NUM_CHAN, 32, number of channel registers; select width is 5.
- OUT_CHANNELS, 16, channels 0..OUT_CHANNELS-1 are Core-writable outputs; the rest are peripheral-writable inputs.
- FIFO_DEPTH, 4, output event queue depth; power of two, ≥2.
- DATA_W, 15, channel word width.

Ports:
- clock  input  1  system clock
- rst_l  input  1  asynchronous active-low reset
- IO_write_en  input  1  Core write strobe (writeback stage)
- IO_write_sel  input  5  Core write channel
- IO_write_data  input  15  Core write data
- IO_read_sel  input  5  Core read channel (decode stage)
- IO_read_data  output  15  channel read data (combinational)
- ext_in_valid  input  1  peripheral input-write request
- ext_in_sel  input  5  peripheral target channel
- ext_in_data  input  15  peripheral data
- ext_in_ready  output  1  peripheral write accepted
- ext_out_valid  output  1  event available
- ext_out_ready  input  1  peripheral consumes event
- ext_out_sel  output  5  event channel
- ext_out_data  output  15  event data
- overflow  output  1  sticky: event dropped on full queue
- bad_write  output  1  sticky: write to a channel outside the writer's range

Behaviour:
- Reset (async, rst_l low):
  - all channel registers 0.
  - queue empty; ext_out_valid 0; ext_out_sel/ext_out_data 0.
  - overflow 0, bad_write 0, ext_in_ready 1.
  - Reset mid-operation discards queued events without emitting them.
- Core write, IO_write_en=1 and sel < OUT_CHANNELS:
  - register updates at the next edge.
  - same edge pushes {sel,data} into the queue.
- Core write with sel ≥ OUT_CHANNELS: no register change, no push; bad_write set next edge.
- Peripheral write:
  - ext_in_ready is always 1; a transfer occurs when ext_in_valid=1.
  - sel ≥ OUT_CHANNELS: register updates next edge.
  - sel < OUT_CHANNELS: ignored; bad_write set.
- Core and peripheral writes in the same cycle target disjoint ranges, so both take effect.
- Read:
  - IO_read_data = register[IO_read_sel], combinational.
  - Write bypass: if IO_write_en=1, IO_write_sel == IO_read_sel and the write is legal, return IO_write_data. Same rule for a legal peripheral write to the read channel.
  - Core bypass wins if both match (cannot both be legal).
- Queue:
  - Synchronous FIFO; ext_out_* show the head entry while ext_out_valid=1, and hold stable until popped.
  - Pop occurs when ext_out_valid && ext_out_ready.
  - Push+pop in the same cycle when full: both succeed, no overflow.
  - Push when full without pop: entry dropped, register still written, overflow set.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count is $clog2(FIFO_DEPTH)+1 bits.
- Latency:
  - Core write → event visible on ext_out_valid: 1 cycle.
  - Write → non-bypassed read: 1 cycle.
- Sticky flags clear only on reset.

Optional Feature:
- Macro IO_CHAN_INTERRUPT_EN.
- When defined, adds:
  - output irq (1), high while any pending bit is set.
  - input irq_ack (1).
  - input irq_ack_sel (5).
- Pending bits: a peripheral write that changes an input channel's value sets that channel's pending bit. irq_ack clears bit irq_ack_sel next edge; a set in the same cycle wins.
- Without the macro: no irq ports, no pending state.

Decomposition:
- Package io_pkg holds:
  - chan_sel_t (5b), io_word_t (15b).
  - io_event_t struct {sel, data}.
  - constants NUM_CHAN, OUT_CHANNELS_DEFAULT.
- Sub-module io_event_fifo: parameterised sync FIFO of io_event_t with push/pop/full/empty/overflow.

Test Plan:
- Reset, then write ch3=0o12345 from Core → next cycle ext_out_valid=1, ext_out_sel=3, ext_out_data=0o12345; read sel 3 returns 0o12345.
- Core writes ch5=0o777 while IO_read_sel=5 → IO_read_data=0o777 in the same cycle (bypass).
- ext_out_ready=0; 5 Core writes with FIFO_DEPTH=4 → first 4 retained in order, overflow=1, ch register holds 5th value.
- Queue full, Core write plus ext_out_ready=1 in the same cycle → head pops, new entry appended, overflow stays 0.
- Peripheral writes ch20=0o40000 → read 20 returns 0o40000. Peripheral writes ch2 → ignored, bad_write=1. Core writes ch20 → ignored, bad_write=1.
- IO_CHAN_INTERRUPT_EN: peripheral changes ch17 → irq=1; irq_ack with sel 17 → irq=0 next edge; rewriting the same value → irq stays 0.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the IO channel bank
package io_pkg;

    localparam int NUM_CHAN             = 32;
    localparam int OUT_CHANNELS_DEFAULT = 16;
    localparam int SEL_W                = 5;
    localparam int DATA_W               = 15;

    typedef logic [SEL_W-1:0]  chan_sel_t;
    typedef logic [DATA_W-1:0] io_word_t;

    // One queued output-channel write as seen by the peripherals
    typedef struct packed {
        chan_sel_t sel;
        io_word_t  data;
    } io_event_t;

endpackage

// File: rtl/io_event_fifo.sv
// rtl/io_event_fifo.sv - synchronous event FIFO with sticky drop flag
module io_event_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      rst_l,
    input  logic      push,
    input  io_event_t push_data,
    input  logic      pop,
    output io_event_t head,
    output logic      empty,
    output logic      overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    io_event_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop_eff;
    logic             push_eff;
    logic             overflow_q;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // A pop frees a slot in the same cycle, so push into a full queue succeeds when paired with a pop
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    // Head is forced to zero when empty so stale storage never leaks onto the event port
    assign head     = empty ? '0 : mem[rd_ptr];
    assign overflow = overflow_q;

    // Pointer, occupancy and drop-flag state; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && full && !pop_eff) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Event storage; contents are only observable through head while occupied
    always_ff @(posedge clock) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/io_channel_bank.sv
// rtl/io_channel_bank.sv - 32-channel IO register bank with output event queue (optional IO_CHAN_INTERRUPT_EN)
module io_channel_bank
    import io_pkg::*;
#(
    parameter int OUT_CHANNELS = OUT_CHANNELS_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clock,
    input  logic      rst_l,
    input  logic      IO_write_en,
    input  chan_sel_t IO_write_sel,
    input  io_word_t  IO_write_data,
    input  chan_sel_t IO_read_sel,
    output io_word_t  IO_read_data,
    input  logic      ext_in_valid,
    input  chan_sel_t ext_in_sel,
    input  io_word_t  ext_in_data,
    output logic      ext_in_ready,
    output logic      ext_out_valid,
    input  logic      ext_out_ready,
    output chan_sel_t ext_out_sel,
    output io_word_t  ext_out_data,
`ifdef IO_CHAN_INTERRUPT_EN
    output logic      irq,
    input  logic      irq_ack,
    input  chan_sel_t irq_ack_sel,
`endif
    output logic      overflow,
    output logic      bad_write
);

    io_word_t  chan_q [NUM_CHAN];
    logic      core_legal;
    logic      ext_legal;
    logic      bad_now;
    logic      bad_write_q;
    logic      fifo_empty;
    io_event_t fifo_head;
    io_event_t push_event;

    // Core owns the low channels, peripherals own the rest
    assign core_legal   = IO_write_en && (int'(IO_write_sel) < OUT_CHANNELS);
    assign ext_legal    = ext_in_valid && (int'(ext_in_sel) >= OUT_CHANNELS);
    assign bad_now      = (IO_write_en && !core_legal) || (ext_in_valid && !ext_legal);
    assign ext_in_ready = 1'b1;
    assign bad_write    = bad_write_q;

    assign push_event.sel  = IO_write_sel;
    assign push_event.data = IO_write_data;

    // Channel registers; the two writers cover disjoint ranges so both may land on one edge
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            if (core_legal) begin
                chan_q[IO_write_sel] <= IO_write_data;
            end
            if (ext_legal) begin
                chan_q[ext_in_sel] <= ext_in_data;
            end
        end
    end

    // Sticky record of any write aimed outside its writer's range
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            bad_write_q <= 1'b0;
        end else if (bad_now) begin
            bad_write_q <= 1'b1;
        end
    end

    // Decode-stage read with same-cycle write bypass, Core write checked first
    always_comb begin
        IO_read_data = chan_q[IO_read_sel];
        if (core_legal && (IO_write_sel == IO_read_sel)) begin
            IO_read_data = IO_write_data;
        end else if (ext_legal && (ext_in_sel == IO_read_sel)) begin
            IO_read_data = ext_in_data;
        end
    end

    io_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clock     (clock),
        .rst_l     (rst_l),
        .push      (core_legal),
        .push_data (push_event),
        .pop       (ext_out_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign ext_out_valid = !fifo_empty;
    assign ext_out_sel   = fifo_head.sel;
    assign ext_out_data  = fifo_head.data;

`ifdef IO_CHAN_INTERRUPT_EN
    logic [NUM_CHAN-1:0] pending_q;
    logic [NUM_CHAN-1:0] set_mask;
    logic [NUM_CHAN-1:0] ack_mask;

    // A peripheral write raises pending only when it actually changes the stored value
    always_comb begin
        set_mask = '0;
        ack_mask = '0;
        if (ext_legal && (ext_in_data != chan_q[ext_in_sel])) begin
            set_mask[ext_in_sel] = 1'b1;
        end
        if (irq_ack) begin
            ack_mask[irq_ack_sel] = 1'b1;
        end
    end

    // Pending bits; a set in the same cycle as its acknowledge wins
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~ack_mask) | set_mask;
        end
    end

    assign irq = |pending_q;
`endif

endmodule

// File: tb/tb_io_channel_bank.sv
// tb/tb_io_channel_bank.sv - self-checking bench for io_channel_bank
module tb_io_channel_bank;

    localparam int OUT   = 16;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst_l;
    logic        IO_write_en;
    logic [4:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic [4:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        ext_in_valid;
    logic [4:0]  ext_in_sel;
    logic [14:0] ext_in_data;
    logic        ext_in_ready;
    logic        ext_out_valid;
    logic        ext_out_ready;
    logic [4:0]  ext_out_sel;
    logic [14:0] ext_out_data;
    logic        overflow;
    logic        bad_write;
`ifdef IO_CHAN_INTERRUPT_EN
    logic        irq;
    logic        irq_ack;
    logic [4:0]  irq_ack_sel;
`endif

    int checks = 0;
    int errors = 0;

    io_channel_bank #(
        .OUT_CHANNELS (OUT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock         (clock),
        .rst_l         (rst_l),
        .IO_write_en   (IO_write_en),
        .IO_write_sel  (IO_write_sel),
        .IO_write_data (IO_write_data),
        .IO_read_sel   (IO_read_sel),
        .IO_read_data  (IO_read_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_sel    (ext_in_sel),
        .ext_in_data   (ext_in_data),
        .ext_in_ready  (ext_in_ready),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ext_out_sel   (ext_out_sel),
        .ext_out_data  (ext_out_data),
`ifdef IO_CHAN_INTERRUPT_EN
        .irq           (irq),
        .irq_ack       (irq_ack),
        .irq_ack_sel   (irq_ack_sel),
`endif
        .overflow      (overflow),
        .bad_write     (bad_write)
    );

    always #5 clock = ~clock;

    // Reference model: plain arrays and a queue of {sel,data} events
    logic [14:0] m_reg [32];
    logic [19:0] m_q [$];
    logic        m_ovf;
    logic        m_bad;
    logic        m_pend [32];
    logic        m_cw;
    logic        m_ew;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_q.delete();
            m_ovf = 1'b0;
            m_bad = 1'b0;
        end else begin
            m_cw = IO_write_en && (IO_write_sel < OUT);
            m_ew = ext_in_valid && (ext_in_sel >= OUT);
            if ((IO_write_en && !m_cw) || (ext_in_valid && !m_ew)) m_bad = 1'b1;
`ifdef IO_CHAN_INTERRUPT_EN
            if (irq_ack) m_pend[irq_ack_sel] = 1'b0;
`endif
            if (m_ew && (m_reg[ext_in_sel] != ext_in_data)) m_pend[ext_in_sel] = 1'b1;
            if (m_q.size() != 0 && ext_out_ready) void'(m_q.pop_front());
            if (m_cw) begin
                if (m_q.size() < DEPTH) m_q.push_back({IO_write_sel, IO_write_data});
                else m_ovf = 1'b1;
                m_reg[IO_write_sel] = IO_write_data;
            end
            if (m_ew) m_reg[ext_in_sel] = ext_in_data;
        end
    end

    function automatic logic [14:0] exp_read();
        if (IO_write_en && IO_write_sel < OUT && IO_write_sel == IO_read_sel) return IO_write_data;
        if (ext_in_valid && ext_in_sel >= OUT && ext_in_sel == IO_read_sel) return ext_in_data;
        return m_reg[IO_read_sel];
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        logic [19:0] hd;
        logic        any;
        hd = (m_q.size() != 0) ? m_q[0] : 20'h0;
        chk("read_data", 32'(IO_read_data), 32'(exp_read()));
        chk("out_valid", 32'(ext_out_valid), 32'(m_q.size() != 0));
        chk("out_sel", 32'(ext_out_sel), 32'(hd[19:15]));
        chk("out_data", 32'(ext_out_data), 32'(hd[14:0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("bad_write", 32'(bad_write), 32'(m_bad));
        chk("in_ready", 32'(ext_in_ready), 32'd1);
        any = 1'b0;
        for (int i = 0; i < 32; i++) any = any | m_pend[i];
`ifdef IO_CHAN_INTERRUPT_EN
        chk("irq", 32'(irq), 32'(any));
`endif
    end

    task automatic idle();
        IO_write_en   = 1'b0;
        IO_write_sel  = '0;
        IO_write_data = '0;
        ext_in_valid  = 1'b0;
        ext_in_sel    = '0;
        ext_in_data   = '0;
        ext_out_ready = 1'b0;
`ifdef IO_CHAN_INTERRUPT_EN
        irq_ack       = 1'b0;
        irq_ack_sel   = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic core_wr(input logic [4:0] s, input logic [14:0] d);
        IO_write_en   = 1'b1;
        IO_write_sel  = s;
        IO_write_data = d;
    endtask

    task automatic ext_wr(input logic [4:0] s, input logic [14:0] d);
        ext_in_valid = 1'b1;
        ext_in_sel   = s;
        ext_in_data  = d;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        #2;
        repeat (2) @(posedge clock);
        #1;
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b1;
        idle();
        IO_read_sel = '0;
        #1;
        do_reset();
        chk("rst_valid", 32'(ext_out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_bad", 32'(bad_write), 32'd0);
        chk("rst_read0", 32'(IO_read_data), 32'd0);
        chk("rst_ready", 32'(ext_in_ready), 32'd1);

        // First Core write becomes an event one cycle later
        core_wr(5'd3, 15'o12345);
        tick();
        chk("ev_valid", 32'(ext_out_valid), 32'd1);
        chk("ev_sel", 32'(ext_out_sel), 32'd3);
        chk("ev_data", 32'(ext_out_data), 32'o12345);
        IO_read_sel = 5'd3;
        #1;
        chk("rd_ch3", 32'(IO_read_data), 32'o12345);
        ext_out_ready = 1'b1;
        tick();
        chk("ev_popped", 32'(ext_out_valid), 32'd0);

        // Same-cycle bypass on the Core write port
        core_wr(5'd5, 15'o777);
        IO_read_sel = 5'd5;
        #1;
        chk("bypass_core", 32'(IO_read_data), 32'o777);
        tick();
        ext_out_ready = 1'b1;
        tick();

        // Fill the queue, then push and pop together while full
        for (int k = 1; k <= 4; k++) begin
            core_wr(5'd9, 15'(k));
            tick();
        end
        chk("full_head", 32'(ext_out_data), 32'd1);
        core_wr(5'd9, 15'd5);
        ext_out_ready = 1'b1;
        tick();
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk("drain_pp", 32'(ext_out_data), 32'(k));
            ext_out_ready = 1'b1;
            tick();
        end
        chk("drain_empty", 32'(ext_out_valid), 32'd0);

        // Five writes into a four-deep queue with no consumer
        for (int k = 1; k <= 5; k++) begin
            core_wr(5'd7, 15'(11 * k));
            tick();
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        IO_read_sel = 5'd7;
        #1;
        chk("ovf_reg", 32'(IO_read_data), 32'd55);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", 32'(ext_out_data), 32'(11 * k));
            ext_out_ready = 1'b1;
            tick();
        end
        chk("ovf_empty", 32'(ext_out_valid), 32'd0);

        // Peripheral writes, including bypass and a concurrent Core write
        ext_wr(5'd20, 15'o40000);
        IO_read_sel = 5'd20;
        #1;
        chk("bypass_ext", 32'(IO_read_data), 32'o40000);
        tick();
        chk("rd_ch20", 32'(IO_read_data), 32'o40000);
        chk("bad_clear", 32'(bad_write), 32'd0);
        core_wr(5'd4, 15'o1234);
        ext_wr(5'd21, 15'o4321);
        IO_read_sel = 5'd21;
        tick();
        chk("both_ch21", 32'(IO_read_data), 32'o4321);
        IO_read_sel = 5'd4;
        #1;
        chk("both_ch4", 32'(IO_read_data), 32'o1234);
        ext_wr(5'd2, 15'o7);
        tick();
        chk("bad_ext", 32'(bad_write), 32'd1);
        IO_read_sel = 5'd2;
        #1;
        chk("ch2_kept", 32'(IO_read_data), 32'd0);

        // Reset drops queued events and clears the flags
        core_wr(5'd1, 15'd100);
        tick();
        do_reset();
        chk("rst2_valid", 32'(ext_out_valid), 32'd0);
        chk("rst2_bad", 32'(bad_write), 32'd0);
        core_wr(5'd20, 15'd1);
        tick();
        chk("bad_core", 32'(bad_write), 32'd1);
        chk("bad_core_noev", 32'(ext_out_valid), 32'd0);
        IO_read_sel = 5'd20;
        #1;
        chk("bad_core_reg", 32'(IO_read_data), 32'd0);

`ifdef IO_CHAN_INTERRUPT_EN
        chk("irq_idle", 32'(irq), 32'd0);
        ext_wr(5'd17, 15'd5);
        tick();
        chk("irq_set", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        irq_ack_sel = 5'd17;
        tick();
        chk("irq_ack", 32'(irq), 32'd0);
        ext_wr(5'd17, 15'd5);
        tick();
        chk("irq_same", 32'(irq), 32'd0);
        ext_wr(5'd17, 15'd6);
        irq_ack = 1'b1;
        irq_ack_sel = 5'd17;
        tick();
        chk("irq_setwins", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        irq_ack_sel = 5'd17;
        tick();
        chk("irq_ack2", 32'(irq), 32'd0);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
